// File: rtl/crc_parallel_gen_if.sv
// Word-level bus between the framer and the CRC engine: message words in, checksum words out.
interface crc_parallel_gen_if #(
    parameter int DATA_W = 8
);
    logic              load;
    logic              in_valid;
    logic              d_finish;
    logic [DATA_W-1:0] crc_in;
    logic [DATA_W-1:0] crc_out;
    logic              out_valid;
    logic              crc_done;
    logic              busy;

    modport master (
        output load, in_valid, d_finish, crc_in,
        input  crc_out, out_valid, crc_done, busy
    );

    modport slave (
        input  load, in_valid, d_finish, crc_in,
        output crc_out, out_valid, crc_done, busy
    );
endinterface

// File: rtl/crc_parallel_gen.sv
// Parametrised parallel CRC engine: one DATA_W word per cycle, checksum emitted MSB word first.
// Optional macro CRC_REFLECT_EN selects reflected (LSB-first) input and output, e.g. Ethernet CRC-32.
module crc_parallel_gen #(
    parameter int                DATA_W = 8,
    parameter int                CRC_W  = 32,
    parameter logic [CRC_W-1:0]  POLY   = 32'h04C11DB7,
    parameter logic [CRC_W-1:0]  INIT   = 32'hFFFFFFFF,
    parameter logic [CRC_W-1:0]  XOROUT = 32'hFFFFFFFF
) (
    input  logic                clk,
    input  logic                rst,
    crc_parallel_gen_if.slave   bus
);

    localparam int NW    = CRC_W / DATA_W;
    localparam int CNT_W = $clog2(NW + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    if ((CRC_W % DATA_W) != 0) begin : g_bad_width
        $error("crc_parallel_gen: DATA_W must divide CRC_W");
    end

    logic [1:0]        r_state;
    logic [CRC_W-1:0]  r_crc;
    logic [CRC_W-1:0]  r_final;
    logic [DATA_W-1:0] r_crc_out;
    logic              r_out_valid;
    logic              r_crc_done;
    logic [CNT_W-1:0]  r_cnt;

    logic [DATA_W-1:0] w_din;
    logic [CRC_W-1:0]  w_crc_upd;
    logic [CRC_W-1:0]  w_final;

    // Unrolled MSB-first bit-serial LFSR; synthesises to a single XOR network.
    function automatic logic [CRC_W-1:0] crc_next(input logic [CRC_W-1:0] c,
                                                  input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ d[i];
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] word_sel(input logic [CRC_W-1:0] f,
                                                   input logic [CNT_W-1:0] idx);
        logic [CRC_W-1:0] sh;
        sh = f >> ((NW - 1 - int'(idx)) * DATA_W);
        return sh[DATA_W-1:0];
    endfunction

`ifdef CRC_REFLECT_EN
    function automatic logic [DATA_W-1:0] rev_data(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] rev_crc(input logic [CRC_W-1:0] c);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) r[i] = c[CRC_W-1-i];
        return r;
    endfunction
`endif

    always_comb begin
`ifdef CRC_REFLECT_EN
        w_din = rev_data(bus.crc_in);
`else
        w_din = bus.crc_in;
`endif
        w_crc_upd = bus.in_valid ? crc_next(r_crc, w_din) : r_crc;
`ifdef CRC_REFLECT_EN
        w_final = rev_crc(w_crc_upd) ^ XOROUT;
`else
        w_final = w_crc_upd ^ XOROUT;
`endif
    end

    // r_cnt holds the index of the next word to present; reaching NW means the last word is on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_crc       <= INIT;
            r_final     <= '0;
            r_crc_out   <= '0;
            r_out_valid <= 1'b0;
            r_crc_done  <= 1'b0;
            r_cnt       <= '0;
        end else if (bus.load) begin
            r_state     <= S_CALC;
            r_crc       <= INIT;
            r_crc_out   <= '0;
            r_out_valid <= 1'b0;
            r_crc_done  <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_CALC: begin
                    r_crc <= w_crc_upd;
                    if (bus.d_finish) begin
                        r_final     <= w_final;
                        r_crc_out   <= word_sel(w_final, '0);
                        r_out_valid <= 1'b1;
                        r_crc_done  <= (NW == 1);
                        r_cnt       <= CNT_W'(1);
                        r_state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (r_cnt == CNT_W'(NW)) begin
                        r_state     <= S_IDLE;
                        r_crc_out   <= '0;
                        r_out_valid <= 1'b0;
                        r_crc_done  <= 1'b0;
                        r_cnt       <= '0;
                    end else begin
                        r_crc_out  <= word_sel(r_final, r_cnt);
                        r_crc_done <= (r_cnt == CNT_W'(NW - 1));
                        r_cnt      <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_crc_out   <= '0;
                    r_out_valid <= 1'b0;
                    r_crc_done  <= 1'b0;
                    r_cnt       <= '0;
                end
            endcase
        end
    end

    assign bus.crc_out   = r_crc_out;
    assign bus.out_valid = r_out_valid;
    assign bus.crc_done  = r_crc_done;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_crc_parallel_gen.sv
// Scoreboard bench: default 8-bit instance, XOROUT=0 twin driven in lock-step, and a 16-bit instance.
module tb_crc_parallel_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crc_parallel_gen_if #(.DATA_W(8))  bus0 ();
  crc_parallel_gen_if #(.DATA_W(8))  bus1 ();
  crc_parallel_gen_if #(.DATA_W(16)) bus2 ();

  assign bus1.load     = bus0.load;
  assign bus1.in_valid = bus0.in_valid;
  assign bus1.d_finish = bus0.d_finish;
  assign bus1.crc_in   = bus0.crc_in;

  crc_parallel_gen #(.DATA_W(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  crc_parallel_gen #(.DATA_W(8), .XOROUT(32'h0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  crc_parallel_gen #(.DATA_W(16)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;

`ifdef CRC_REFLECT_EN
  localparam logic [31:0] E_STD = 32'hCBF43926;
  localparam logic [31:0] E_X0  = 32'h340BC6D9;
`else
  localparam logic [31:0] E_STD = 32'hFC891918;
  localparam logic [31:0] E_X0  = 32'h0376E6E7;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference CRC over a byte stream, consumed in w-bit words (8 or 16).
  function automatic logic [31:0] model(input bq_t b, input int w, input logic [31:0] xo);
    logic [31:0] c;
    logic [15:0] d;
    logic [15:0] t;
    logic [31:0] r;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < b.size() * 8 / w; k++) begin
      d = (w == 16) ? {b[2*k], b[2*k+1]} : {8'h00, b[k]};
`ifdef CRC_REFLECT_EN
      t = '0;
      for (int i = 0; i < w; i++) t[i] = d[w-1-i];
      d = t;
`endif
      for (int i = w - 1; i >= 0; i--) begin
        fb = c[31] ^ d[i];
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
    end
    r = c;
`ifdef CRC_REFLECT_EN
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
`endif
    return r ^ xo;
  endfunction

  task automatic push8(input logic [31:0] f0, input logic [31:0] f1, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.last = (k == 3);
      e.data = {8'h00, f0[31-8*k -: 8]};
      q0.push_back(e);
      e.data = {8'h00, f1[31-8*k -: 8]};
      q1.push_back(e);
    end
  endtask

  task automatic push16(input logic [31:0] f);
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.last = (k == 1);
      e.data = f[31-16*k -: 16];
      q2.push_back(e);
    end
  endtask

  task automatic mon(input int which, input logic vld, input logic done, input logic [15:0] data);
    exp_t e;
    int   sz;
    case (which)
      0:       sz = q0.size();
      1:       sz = q1.size();
      default: sz = q2.size();
    endcase
    if (vld === 1'b1) begin
      if (sz == 0) begin
        check($sformatf("unexpected_out%0d", which), vld, 1'b0);
      end else begin
        case (which)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        check($sformatf("word%0d", which), data, e.data);
        check($sformatf("done%0d", which), done, e.last);
      end
    end else begin
      if (done !== 1'b0) check($sformatf("done_no_vld%0d", which), done, 1'b0);
      if (data !== 16'h0) check($sformatf("out_idle_zero%0d", which), data, 16'h0);
    end
  endtask

  always @(negedge clk) if (rst === 1'b0) mon(0, bus0.out_valid, bus0.crc_done, {8'h00, bus0.crc_out});
  always @(negedge clk) if (rst === 1'b0) mon(1, bus1.out_valid, bus1.crc_done, {8'h00, bus1.crc_out});
  always @(negedge clk) if (rst === 1'b0) mon(2, bus2.out_valid, bus2.crc_done, bus2.crc_out);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load();
    bus0.load = 1'b1;
    tick();
    bus0.load = 1'b0;
  endtask

  task automatic feed(input bq_t b, input bit gaps, input bit fin_last);
    for (int k = 0; k < b.size(); k++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) tick();
      bus0.in_valid = 1'b1;
      bus0.crc_in   = b[k];
      if (fin_last && (k == b.size() - 1)) bus0.d_finish = 1'b1;
      tick();
      bus0.in_valid = 1'b0;
      bus0.d_finish = 1'b0;
    end
  endtask

  task automatic finish();
    bus0.d_finish = 1'b1;
    tick();
    bus0.d_finish = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (!bus0.busy && !bus1.busy && !bus2.busy) ok = 1'b1;
    end
    check({tag, "_idle"}, ok, 1'b1);
    check({tag, "_queue_drained"}, q0.size() + q1.size() + q2.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t msg;
    bq_t msg8;
    bq_t abc;
    bit  fl;
    msg  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    msg8 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
    abc  = '{8'h61, 8'h62, 8'h63};

    rst = 1'b1;
    bus0.load = 1'b0; bus0.in_valid = 1'b0; bus0.d_finish = 1'b0; bus0.crc_in = '0;
    bus2.load = 1'b0; bus2.in_valid = 1'b0; bus2.d_finish = 1'b0; bus2.crc_in = '0;
    #2;
    check("rst_busy", bus0.busy, 1'b0);
    check("rst_out_valid", bus0.out_valid, 1'b0);
    check("rst_crc_out", bus0.crc_out, 8'h00);
    check("rst_crc_done", bus0.crc_done, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Standard check vector, finish in a separate cycle.
    push8(E_STD, E_X0, 4);
    do_load();
    check("calc_busy", bus0.busy, 1'b1);
    feed(msg, 1'b0, 1'b0);
    finish();
    wait_idle("std");

    // d_finish together with the last byte.
    push8(E_STD, E_X0, 4);
    do_load();
    feed(msg, 1'b0, 1'b1);
    wait_idle("fin_last");

    // Zero-length message.
    push8(32'h00000000, 32'hFFFFFFFF, 4);
    do_load();
    finish();
    wait_idle("zero_len");

    // Gapped input.
    for (int r = 0; r < 3; r++) begin
      fl = 1'($urandom_range(0, 1));
      push8(E_STD, E_X0, 4);
      do_load();
      feed(msg, 1'b1, fl);
      if (!fl) finish();
      wait_idle("gapped");
    end

    // Asynchronous reset mid-message, then a normal message.
    do_load();
    feed(abc, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_busy", bus0.busy, 1'b0);
    check("midrst_out_valid", bus0.out_valid, 1'b0);
    check("midrst_crc_out", bus0.crc_out, 8'h00);
    tick();
    rst = 1'b0;
    push8(E_STD, E_X0, 4);
    do_load();
    feed(msg, 1'b0, 1'b0);
    finish();
    wait_idle("after_rst");

    // load during OUT after two words.
    push8(E_STD, E_X0, 2);
    do_load();
    feed(msg, 1'b0, 1'b0);
    bus0.d_finish = 1'b1;
    tick();
    bus0.d_finish = 1'b0;
    tick();
    bus0.load = 1'b1;
    tick();
    bus0.load = 1'b0;
    check("abort_out_valid", bus0.out_valid, 1'b0);
    check("abort_busy", bus0.busy, 1'b1);
    push8(model(abc, 8, 32'hFFFFFFFF), model(abc, 8, 32'h0), 4);
    feed(abc, 1'b0, 1'b0);
    finish();
    wait_idle("abort");

    // load and d_finish together: stay in CALC, no output.
    do_load();
    feed(abc, 1'b0, 1'b0);
    bus0.load = 1'b1;
    bus0.d_finish = 1'b1;
    tick();
    bus0.load = 1'b0;
    bus0.d_finish = 1'b0;
    repeat (3) tick();
    check("ld_fin_busy", bus0.busy, 1'b1);
    check("ld_fin_out_valid", bus0.out_valid, 1'b0);
    push8(E_STD, E_X0, 4);
    feed(msg, 1'b0, 1'b0);
    finish();
    wait_idle("ld_fin");

    // 8-bit run of "12345678" and the same bytes on the 16-bit instance.
    push8(model(msg8, 8, 32'hFFFFFFFF), model(msg8, 8, 32'h0), 4);
    do_load();
    feed(msg8, 1'b0, 1'b0);
    finish();
    wait_idle("msg8");

`ifdef CRC_REFLECT_EN
    push16(model(msg8, 16, 32'hFFFFFFFF));
`else
    push16(model(msg8, 8, 32'hFFFFFFFF));
`endif
    bus2.load = 1'b1;
    tick();
    bus2.load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus2.in_valid = 1'b1;
      bus2.crc_in   = {msg8[2*k], msg8[2*k+1]};
      tick();
    end
    bus2.in_valid = 1'b0;
    bus2.d_finish = 1'b1;
    tick();
    bus2.d_finish = 1'b0;
    wait_idle("w16");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
